// File: rtl/booth_simd_multiplier.sv
// Sequential radix-2 Booth multiplier with SIMD lane modes.
// Mode 0 multiplies lane 0 only, mode 1 runs every lane as an independent
// LANE_W x LANE_W product, mode 2 forms one DW x DW product, mode 3 is
// reported as illegal. One transaction is in flight at a time.
//
// Handshake: an input transaction is taken at a rising edge where
// in_valid_i & in_ready_o; a result is consumed at a rising edge where
// out_valid_o & out_ready_i. in_ready_o is high only in IDLE, and
// product_o / illegal_o stay stable while out_valid_o is high.
module booth_simd_multiplier #(
  parameter int LANE_W = 8,
  parameter int LANES  = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [1:0]                    mode_i,
  input  logic                          signed_i,
  input  logic [LANES*LANE_W-1:0]       multiplicand_i,
  input  logic [LANES*LANE_W-1:0]       multiplier_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [2*LANES*LANE_W-1:0]     product_o,
  output logic                          illegal_o,
  output logic [1:0]                    state_o
);

  localparam int DW = LANES * LANE_W;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            full_mode;
  logic            lane0_only;

  // Full-width engine: {hi, q, qm1} shifts right once per iteration.
  // Operands carry one extra bit so unsigned values become non-negative
  // signed values and the most-negative signed case cannot overflow.
  logic [DW:0]     full_m;
  logic [DW:0]     full_hi;
  logic [DW:0]     full_q;
  logic            full_qm1;
  logic [DW+1:0]   full_sum;
  logic [DW:0]     full_hi_nxt;
  logic [DW:0]     full_q_nxt;
  logic [2*DW-1:0] full_pack;

  // Per-lane engines, same structure at LANE_W+1 bits.
  logic [LANE_W:0]   lane_m      [LANES];
  logic [LANE_W:0]   lane_hi     [LANES];
  logic [LANE_W:0]   lane_q      [LANES];
  logic              lane_qm1    [LANES];
  logic [LANE_W+1:0] lane_sum    [LANES];
  logic [LANE_W:0]   lane_hi_nxt [LANES];
  logic [LANE_W:0]   lane_q_nxt  [LANES];
  logic [2*DW-1:0]   lane_pack;

  logic [CW-1:0]   last_cnt;

  assign in_ready_o = (state == IDLE);
  assign state_o    = state;
  assign last_cnt   = full_mode ? CW'(DW) : CW'(LANE_W);

  // One Booth step of the full-width engine; the sum is one bit wider so
  // the arithmetic right shift keeps the exact value.
  always_comb begin
    full_sum = {full_hi[DW], full_hi};
    case ({full_q[0], full_qm1})
      2'b01:   full_sum = {full_hi[DW], full_hi} + {full_m[DW], full_m};
      2'b10:   full_sum = {full_hi[DW], full_hi} - {full_m[DW], full_m};
      default: full_sum = {full_hi[DW], full_hi};
    endcase
    full_hi_nxt = full_sum[DW+1:1];
    full_q_nxt  = {full_sum[0], full_q[DW:1]};
    full_pack   = {full_hi_nxt[DW-2:0], full_q_nxt};
  end

  // One Booth step per lane; each lane packs into its own 2*LANE_W field
  // so nothing carries across lane boundaries. Mode 0 blanks lanes > 0.
  always_comb begin
    lane_pack = '0;
    for (int k = 0; k < LANES; k++) begin
      case ({lane_q[k][0], lane_qm1[k]})
        2'b01:   lane_sum[k] = {lane_hi[k][LANE_W], lane_hi[k]} + {lane_m[k][LANE_W], lane_m[k]};
        2'b10:   lane_sum[k] = {lane_hi[k][LANE_W], lane_hi[k]} - {lane_m[k][LANE_W], lane_m[k]};
        default: lane_sum[k] = {lane_hi[k][LANE_W], lane_hi[k]};
      endcase
      lane_hi_nxt[k] = lane_sum[k][LANE_W+1:1];
      lane_q_nxt[k]  = {lane_sum[k][0], lane_q[k][LANE_W:1]};
      if (!(lane0_only && k != 0)) begin
        lane_pack[2*LANE_W*k +: 2*LANE_W] = {lane_hi_nxt[k][LANE_W-2:0], lane_q_nxt[k]};
      end
    end
  end

  // Control FSM plus engine registers; all outputs are registered here.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      full_mode   <= 1'b0;
      lane0_only  <= 1'b0;
      out_valid_o <= 1'b0;
      illegal_o   <= 1'b0;
      product_o   <= '0;
      full_m      <= '0;
      full_hi     <= '0;
      full_q      <= '0;
      full_qm1    <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        lane_m[k]   <= '0;
        lane_hi[k]  <= '0;
        lane_q[k]   <= '0;
        lane_qm1[k] <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            if (mode_i == 2'd3) begin
              state       <= DONE;
              out_valid_o <= 1'b1;
              illegal_o   <= 1'b1;
              product_o   <= '0;
            end else begin
              state      <= BUSY;
              cnt        <= '0;
              full_mode  <= (mode_i == 2'd2);
              lane0_only <= (mode_i == 2'd0);
              full_m     <= {signed_i & multiplicand_i[DW-1], multiplicand_i};
              full_q     <= {signed_i & multiplier_i[DW-1], multiplier_i};
              full_hi    <= '0;
              full_qm1   <= 1'b0;
              for (int k = 0; k < LANES; k++) begin
                lane_m[k]   <= {signed_i & multiplicand_i[LANE_W*(k+1)-1],
                                multiplicand_i[LANE_W*k +: LANE_W]};
                lane_q[k]   <= {signed_i & multiplier_i[LANE_W*(k+1)-1],
                                multiplier_i[LANE_W*k +: LANE_W]};
                lane_hi[k]  <= '0;
                lane_qm1[k] <= 1'b0;
              end
            end
          end
        end
        BUSY: begin
          full_hi  <= full_hi_nxt;
          full_q   <= full_q_nxt;
          full_qm1 <= full_q[0];
          for (int k = 0; k < LANES; k++) begin
            lane_hi[k]  <= lane_hi_nxt[k];
            lane_q[k]   <= lane_q_nxt[k];
            lane_qm1[k] <= lane_q[k][0];
          end
          if (cnt == last_cnt) begin
            state       <= DONE;
            out_valid_o <= 1'b1;
            illegal_o   <= 1'b0;
            product_o   <= full_mode ? full_pack : lane_pack;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_simd_multiplier.sv
// Directed bench for booth_simd_multiplier at LANE_W=8, LANES=2.
module tb_booth_simd_multiplier;

  localparam int LANE_W = 8;
  localparam int LANES  = 2;
  localparam int DW     = LANE_W * LANES;

  logic            clk;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      mode;
  logic            sgn;
  logic [DW-1:0]   op_a;
  logic [DW-1:0]   op_b;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] product;
  logic            illegal;
  logic [1:0]      state_dbg;

  int total;
  int bad;

  booth_simd_multiplier #(.LANE_W(LANE_W), .LANES(LANES)) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .mode_i         (mode),
    .signed_i       (sgn),
    .multiplicand_i (op_a),
    .multiplier_i   (op_b),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .product_o      (product),
    .illegal_o      (illegal),
    .state_o        (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      mode;
    logic            sgn;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [2*DW-1:0] exp_prod;
    logic            exp_ill;
    int              exp_lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: wait for in_ready, present one transaction for one edge.
  task automatic send(input logic [1:0] m, input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_send", 64'(in_ready), 64'd1);
    mode = m; sgn = s; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mode = $urandom_range(0, 3);
    op_a = $urandom_range(0, 65535);
    op_b = $urandom_range(0, 65535);
  endtask

  // Count edges after the acceptance edge until out_valid is seen.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      if (out_valid) break;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_handshake_in_ready", 64'(in_ready), 64'd1);
    check("post_handshake_out_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    send(v.mode, v.sgn, v.a, v.b);
    wait_valid(lat);
    check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, "_product"}, 64'(product), 64'(v.exp_prod));
    check({tag, "_illegal"}, 64'(illegal), 64'(v.exp_ill));
    consume();
  endtask

  initial begin
    int lat;
    logic [2*DW-1:0] held;
    total = 0; bad = 0;
    in_valid = 1'b0; out_ready = 1'b0; mode = 2'd0; sgn = 1'b0; op_a = '0; op_b = '0;

    vecs[0]  = '{2'd2, 1'b1, 16'hFFFF, 16'h0002, 32'hFFFF_FFFE, 1'b0, 17};
    vecs[1]  = '{2'd2, 1'b0, 16'hFFFF, 16'h0002, 32'h0001_FFFE, 1'b0, 17};
    vecs[2]  = '{2'd1, 1'b1, 16'h7F80, 16'h0280, 32'h00FE_4000, 1'b0, 9};
    vecs[3]  = '{2'd1, 1'b0, 16'h7F80, 16'h0280, 32'h00FE_4000, 1'b0, 9};
    vecs[4]  = '{2'd1, 1'b0, 16'hFF01, 16'hFF01, 32'hFE01_0001, 1'b0, 9};
    vecs[5]  = '{2'd0, 1'b0, 16'h12FF, 16'h34FF, 32'h0000_FE01, 1'b0, 9};
    vecs[6]  = '{2'd0, 1'b1, 16'h12FF, 16'h34FF, 32'h0000_0001, 1'b0, 9};
    vecs[7]  = '{2'd3, 1'b0, 16'hABCD, 16'h1234, 32'h0000_0000, 1'b1, 1};
    vecs[8]  = '{2'd2, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 17};
    vecs[9]  = '{2'd1, 1'b1, 16'h80FF, 16'h8002, 32'h4000_FFFE, 1'b0, 9};
    vecs[10] = '{2'd2, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 17};
    vecs[11] = '{2'd2, 1'b1, 16'h1234, 16'hFFFF, 32'hFFFF_EDCC, 1'b0, 17};
    vecs[12] = '{2'd0, 1'b1, 16'h7F80, 16'h0380, 32'h0000_4000, 1'b0, 9};

    // Reset state
    reset_n = 1'b0;
    #23;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    check("reset_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // out_ready while idle does nothing
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_out_ready_valid", 64'(out_valid), 64'd0);
    check("idle_out_ready_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-pressure: result held 20 cycles, new requests ignored
    send(2'd1, 1'b1, 16'h7F80, 16'h0280);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'd9);
    held = product;
    check("bp_product", 64'(held), 64'h00FE_4000);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = (c % 3 == 0);
      mode = 2'd3; op_a = 16'h5555; op_b = 16'hAAAA;
      @(posedge clk);
      #1;
      check($sformatf("bp_stable_%0d", c), 64'(product), 64'(held));
      check($sformatf("bp_in_ready_%0d", c), 64'(in_ready), 64'd0);
      check($sformatf("bp_valid_%0d", c), 64'(out_valid), 64'd1);
      check($sformatf("bp_illegal_%0d", c), 64'(illegal), 64'd0);
    end
    in_valid = 1'b0;
    consume();
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_stray_txn", 64'(out_valid), 64'd0);
    check("bp_idle_ready", 64'(in_ready), 64'd1);

    // Reset while holding a result in DONE
    send(2'd2, 1'b0, 16'hFFFF, 16'hFFFF);
    wait_valid(lat);
    check("rd_product_before", 64'(product), 64'hFFFE_0001);
    #2;
    reset_n = 1'b0;
    #1;
    check("rd_out_valid", 64'(out_valid), 64'd0);
    check("rd_product", 64'(product), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset at iteration 5 of a mode-2 operation
    send(2'd2, 1'b1, 16'h1234, 16'hFFFF);
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("rb_out_valid", 64'(out_valid), 64'd0);
    check("rb_product", 64'(product), 64'd0);
    check("rb_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rb_in_ready", 64'(in_ready), 64'd1);
    repeat (20) @(posedge clk);
    #1;
    check("rb_result_discarded", 64'(out_valid), 64'd0);
    run_vec(vecs[0], "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
